// File: rtl/pgm_sprite_linebuf.sv
// Double-buffered sprite line buffer: fetch writes one pixel/cycle, scanout reads the other bank.
// Latency: writes land in one cycle; reads return registered data one cycle after rd_en.
// Backpressure: none; every write is accepted, merged by overlap priority, or dropped and counted.
module pgm_sprite_linebuf #(
    parameter int LINE_W    = 448,
    parameter int X_W       = 10,
    parameter int PIX_BITS  = 5,
    parameter int PAL_BITS  = 5,
    parameter int PRIO_BITS = 2,
    parameter int MODE      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic                 wr_en,
    input  logic [X_W-1:0]       wr_x,
    input  logic [PIX_BITS-1:0]  wr_pix,
    input  logic [PAL_BITS-1:0]  wr_pal,
    input  logic [PRIO_BITS-1:0] wr_prio,
    input  logic                 rd_en,
    input  logic [X_W-1:0]       rd_x,
    output logic                 rd_valid,
    output logic                 rd_opaque,
    output logic [PIX_BITS-1:0]  rd_pix,
    output logic [PAL_BITS-1:0]  rd_pal,
    output logic [PRIO_BITS-1:0] rd_prio,
    output logic [X_W:0]         last_line_cnt,
    output logic [7:0]           drop_cnt
);

    localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ENT_W = PIX_BITS + PAL_BITS + PRIO_BITS;
    localparam logic [X_W-1:0] LINE_W_X   = X_W'(LINE_W);
    localparam logic [X_W:0]   LINE_W_CNT = (X_W + 1)'(LINE_W);

    logic                   bank_sel;
    logic [1:0][LINE_W-1:0] occ;
    logic [ENT_W-1:0]       mem [2][LINE_W];
    logic [X_W:0]           line_cnt;
    logic [X_W:0]           line_cnt_next;

    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_in_range;
    logic                 wr_live;
    logic                 wr_occ;
    logic [PRIO_BITS-1:0] wr_old_prio;
    logic                 wr_win;
    logic                 wr_accept;
    logic                 wr_drop;

    logic [IDX_W-1:0] rd_idx;
    logic             rd_hit;
    logic [ENT_W-1:0] rd_ent;

    assign wr_idx      = wr_x[IDX_W-1:0];
    assign wr_in_range = (wr_x < LINE_W_X);
    assign wr_live     = wr_en && (wr_pix != '0);
    assign wr_occ      = occ[bank_sel][wr_idx];
    assign wr_old_prio = mem[bank_sel][wr_idx][PRIO_BITS-1:0];

    // Overlap policy; occupancy and stored priority are live registers, so a
    // back-to-back write to the same column sees the previous write's result.
    always_comb begin
        wr_win = 1'b0;
        if (MODE == 0) begin
            wr_win = 1'b1;
        end else if (MODE == 2) begin
            wr_win = !wr_occ || (wr_prio > wr_old_prio);
        end else begin
            wr_win = !wr_occ;
        end
    end

    assign wr_accept     = wr_live && wr_in_range && wr_win;
    assign wr_drop       = wr_live && !wr_in_range;
    assign line_cnt_next = (wr_accept && (line_cnt != LINE_W_CNT)) ? line_cnt + 1'b1 : line_cnt;

    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem[bank_sel][wr_idx] <= {wr_pix, wr_pal, wr_prio};
        end
    end

    // The bank being handed to the writer is wiped in one cycle, which is what
    // makes a clear-on-read pass unnecessary.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= '0;
        end else begin
            if (wr_accept) begin
                occ[bank_sel][wr_idx] <= 1'b1;
            end
            if (line_start) begin
                occ[~bank_sel] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel      <= 1'b0;
            line_cnt      <= '0;
            last_line_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            if (line_start) begin
                bank_sel      <= ~bank_sel;
                last_line_cnt <= line_cnt_next;
                line_cnt      <= '0;
            end else begin
                line_cnt <= line_cnt_next;
            end
            if (wr_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign rd_idx = rd_x[IDX_W-1:0];
    assign rd_hit = (rd_x < LINE_W_X) && occ[~bank_sel][rd_idx];
    assign rd_ent = mem[~bank_sel][rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_opaque <= 1'b0;
            rd_pix    <= '0;
            rd_pal    <= '0;
            rd_prio   <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_opaque                  <= rd_hit;
                {rd_pix, rd_pal, rd_prio}  <= rd_hit ? rd_ent : '0;
            end
        end
    end

endmodule
